// File: rtl/framebuffer_xy_clear.sv
// Single-clock x/y framebuffer with a write handshake, a 1-cycle registered
// read port with same-edge write forwarding, out-of-range detection and a
// hardware engine that fills the whole frame with one colour.
module framebuffer_xy_clear #(
  parameter int DATA_WIDTH = 4,
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 7,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [X_WIDTH-1:0]    wr_x_i,
  input  logic [Y_WIDTH-1:0]    wr_y_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_oob_o,
  input  logic                  rd_en_i,
  input  logic [X_WIDTH-1:0]    rd_x_i,
  input  logic [Y_WIDTH-1:0]    rd_y_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  clear_start_i,
  input  logic [DATA_WIDTH-1:0] clear_colour_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o
);

  localparam int NPIX = H_RES * V_RES;
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] HRES_A = ADDR_WIDTH'(H_RES);
  localparam logic [31:0] H_LIM = H_RES;
  localparam logic [31:0] V_LIM = V_RES;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]   colour_q;
  logic                    wr_ready_q, wr_oob_q, clear_busy_q, clear_done_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]   mem_q [NPIX];

  logic                    wr_inr, rd_inr, wr_acc;
  logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Coordinate decode: range checks and linear address y*H_RES + x
  always_comb begin
    wr_inr  = (32'(wr_x_i) < H_LIM) && (32'(wr_y_i) < V_LIM);
    rd_inr  = (32'(rd_x_i) < H_LIM) && (32'(rd_y_i) < V_LIM);
    wr_addr = ADDR_WIDTH'(wr_y_i) * HRES_A + ADDR_WIDTH'(wr_x_i);
    rd_addr = ADDR_WIDTH'(rd_y_i) * HRES_A + ADDR_WIDTH'(rd_x_i);
    // wr_ready only rises in IDLE, so it doubles as the accept qualifier
    wr_acc  = wr_valid_i && wr_ready_q;
  end

  // Single memory write port: clear engine owns it in CLEAR, host otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data_i;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = colour_q;
    end else if (wr_acc && wr_inr) begin
      mem_we    = 1'b1;
    end
  end

  // Pixel storage, not reset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Next read value: zero when out of range, forward a same-edge write
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (!rd_inr)                                rd_data_d = '0;
      else if (mem_we && (mem_waddr == rd_addr))  rd_data_d = mem_wdata;
      else                                        rd_data_d = mem_q[rd_addr];
    end
  end

  // Registered read port, data holds while rd_en is low
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      rd_data_q  <= rd_data_d;
    end
  end

  // Control FSM: write handshake, oob pulse and clear sequencing
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      colour_q     <= '0;
      wr_ready_q   <= 1'b0;
      wr_oob_q     <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      wr_oob_q     <= wr_acc && !wr_inr;
      clear_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wr_ready_q <= 1'b1;
          if (clear_start_i) begin
            state_q      <= S_CLEAR;
            colour_q     <= clear_colour_i;
            cnt_q        <= '0;
            wr_ready_q   <= 1'b0;
            clear_busy_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_A) begin
            state_q      <= S_DONE;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          wr_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Parameter sanity: coordinates and address must hold the full frame
  always_ff @(posedge clk_i) begin
    assert (NPIX <= (1 << ADDR_WIDTH)) else $error("ADDR_WIDTH too small for H_RES*V_RES");
    assert (H_RES <= (1 << X_WIDTH)) else $error("X_WIDTH too small for H_RES");
    assert (V_RES <= (1 << Y_WIDTH)) else $error("Y_WIDTH too small for V_RES");
  end

  assign wr_ready_o   = wr_ready_q;
  assign wr_oob_o     = wr_oob_q;
  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign clear_busy_o = clear_busy_q;
  assign clear_done_o = clear_done_q;

endmodule

// File: tb/tb_framebuffer_xy_clear.sv
// Testbench for framebuffer_xy_clear: directed scenarios plus a randomized
// write/read phase checked against a flat pixel-array reference model.
module tb_framebuffer_xy_clear;

  localparam int DW = 4, HR = 160, VR = 120, XW = 8, YW = 7, AW = 15;
  localparam int NPIX = HR * VR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0, wr_ready, wr_oob;
  logic [XW-1:0] wr_x = '0, rd_x = '0;
  logic [YW-1:0] wr_y = '0, rd_y = '0;
  logic [DW-1:0] wr_data = '0, rd_data, clear_colour = '0;
  logic          rd_en = 1'b0, rd_valid;
  logic          clear_start = 1'b0, clear_busy, clear_done;

  int checks = 0, errors = 0;
  int model [NPIX];
  bit known [NPIX];

  framebuffer_xy_clear #(
    .DATA_WIDTH(DW), .H_RES(HR), .V_RES(VR),
    .X_WIDTH(XW), .Y_WIDTH(YW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_x_i(wr_x), .wr_y_i(wr_y), .wr_data_i(wr_data), .wr_oob_o(wr_oob),
    .rd_en_i(rd_en), .rd_x_i(rd_x), .rd_y_i(rd_y),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .clear_start_i(clear_start), .clear_colour_i(clear_colour),
    .clear_busy_o(clear_busy), .clear_done_o(clear_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic bit inr(int x, int y);
    return (x < HR) && (y < VR);
  endfunction

  task automatic fill_model(int c);
    for (int i = 0; i < NPIX; i++) begin model[i] = c; known[i] = 1'b1; end
  endtask

  // Host write of one pixel (drive only)
  task automatic do_write(int x, int y, int d);
    wr_valid = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_data = DW'(d);
    step();
    wr_valid = 1'b0;
    if (inr(x, y)) begin model[y*HR+x] = d; known[y*HR+x] = 1'b1; end
  endtask

  // Issue one read; rd_data/rd_valid are valid on return
  task automatic do_read(int x, int y);
    rd_en = 1'b1; rd_x = XW'(x); rd_y = YW'(y);
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wr_ready !== 1'b0)   begin errors++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
    checks++; if (wr_oob !== 1'b0)     begin errors++; $display("FAIL rst_wr_oob got %b exp 0", wr_oob); end
    checks++; if (rd_data !== '0)      begin errors++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
    checks++; if (rd_valid !== 1'b0)   begin errors++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_clear_busy got %b exp 0", clear_busy); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL rst_clear_done got %b exp 0", clear_done); end
    reset = 1'b0;
    step();
    checks++; if (wr_ready !== 1'b1)   begin errors++; $display("FAIL rst_release_ready got %b exp 1", wr_ready); end
  endtask

  task automatic test_write_read();
    do_write(3, 2, 'hA);
    checks++; if (wr_oob !== 1'b0) begin errors++; $display("FAIL wr_basic_oob got %b exp 0", wr_oob); end
    do_read(3, 2);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd_basic_valid got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 4'hA)  begin errors++; $display("FAIL rd_basic_data got %h exp a", rd_data); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_idle_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 4'hA)  begin errors++; $display("FAIL rd_hold_data got %h exp a", rd_data); end
    // Address 323 lies in row 2 column 3: confirm neighbours differ
    do_write(2, 2, 'h1);
    do_write(4, 2, 'h2);
    do_read(3, 2);
    checks++; if (rd_data !== 4'hA)  begin errors++; $display("FAIL rd_addr323 got %h exp a", rd_data); end
  endtask

  task automatic test_oob();
    do_write(0, 1, 'hC);
    do_write(159, 119, 'h5);
    checks++; if (wr_oob !== 1'b0) begin errors++; $display("FAIL oob_edge_inrange got %b exp 0", wr_oob); end
    do_write(160, 0, 'hF);
    checks++; if (wr_oob !== 1'b1) begin errors++; $display("FAIL oob_pulse got %b exp 1", wr_oob); end
    step();
    checks++; if (wr_oob !== 1'b0) begin errors++; $display("FAIL oob_pulse_len got %b exp 0", wr_oob); end
    do_read(160, 0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== '0) begin errors++; $display("FAIL oob_read got v=%b d=%h exp v=1 d=0", rd_valid, rd_data); end
    do_read(159, 119);
    checks++; if (rd_data !== 4'h5) begin errors++; $display("FAIL max_coord_read got %h exp 5", rd_data); end
    do_read(0, 1);
    checks++; if (rd_data !== 4'hC) begin errors++; $display("FAIL oob_no_alias got %h exp c", rd_data); end
    do_write(5, 127, 'h9);
    checks++; if (wr_oob !== 1'b1) begin errors++; $display("FAIL oob_y_pulse got %b exp 1", wr_oob); end
  endtask

  task automatic test_forward();
    wr_valid = 1'b1; wr_x = 10; wr_y = 10; wr_data = 'h7;
    rd_en = 1'b1; rd_x = 10; rd_y = 10;
    step();
    wr_valid = 1'b0; rd_en = 1'b0;
    model[10*HR+10] = 'h7; known[10*HR+10] = 1'b1;
    checks++; if (rd_data !== 4'h7) begin errors++; $display("FAIL fwd_same_edge got %h exp 7", rd_data); end
  endtask

  // Random mix of writes and reads, including out-of-range coordinates
  task automatic test_random();
    int wx, wy, wd, rx, ry, ea, eo;
    bit wv, re, ek;
    int last_exp;
    bit last_kn;
    last_exp = int'(rd_data); last_kn = 1'b1;
    for (int n = 0; n < 400; n++) begin
      wv = ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 2) != 0);
      wx = ($urandom_range(0, 7) == 0) ? $urandom_range(HR, 255) : $urandom_range(0, HR-1);
      wy = ($urandom_range(0, 7) == 0) ? $urandom_range(VR, 127) : $urandom_range(0, 7);
      wd = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin rx = wx; ry = wy; end
      else begin
        rx = ($urandom_range(0, 9) == 0) ? $urandom_range(HR, 255) : $urandom_range(0, HR-1);
        ry = ($urandom_range(0, 9) == 0) ? $urandom_range(VR, 127) : $urandom_range(0, 7);
      end
      eo = (wv && !inr(wx, wy)) ? 1 : 0;
      if (re) begin
        if (!inr(rx, ry)) begin last_exp = 0; last_kn = 1'b1; end
        else if (wv && inr(wx, wy) && (wx == rx) && (wy == ry)) begin last_exp = wd; last_kn = 1'b1; end
        else begin ea = ry*HR+rx; last_exp = model[ea]; last_kn = known[ea]; end
      end
      ek = last_kn;
      wr_valid = wv; wr_x = XW'(wx); wr_y = YW'(wy); wr_data = DW'(wd);
      rd_en = re; rd_x = XW'(rx); rd_y = YW'(ry);
      step();
      if (wv && inr(wx, wy)) begin model[wy*HR+wx] = wd; known[wy*HR+wx] = 1'b1; end
      checks++; if (wr_oob !== eo[0]) begin errors++; $display("FAIL rnd_oob n=%0d got %b exp %0d", n, wr_oob, eo); end
      checks++; if (rd_valid !== re) begin errors++; $display("FAIL rnd_rd_valid n=%0d got %b exp %b", n, rd_valid, re); end
      if (ek) begin
        checks++; if (rd_data !== DW'(last_exp)) begin errors++; $display("FAIL rnd_rd_data n=%0d got %h exp %h", n, rd_data, last_exp); end
      end
    end
    wr_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt, rdy_bad;
    do_write(39, 1, 'hC);
    clear_colour = 'h3; clear_start = 1'b1;
    step();
    clear_start = 1'b0; clear_colour = 'h0;
    busy_cnt = 0; done_cnt = 0; rdy_bad = 0;
    wr_valid = 1'b1; wr_x = 80; wr_y = 60; wr_data = 'hE;
    while (clear_busy === 1'b1 && busy_cnt < 20000) begin
      busy_cnt++;
      if (wr_ready !== 1'b0) rdy_bad++;
      if (clear_done === 1'b1) done_cnt++;
      clear_start = (busy_cnt == 50);
      rd_en = (busy_cnt == 200); rd_x = 39; rd_y = 1;
      step();
      if (busy_cnt == 200) begin
        checks++; if (rd_data !== 4'h3) begin errors++; $display("FAIL clr_fwd got %h exp 3", rd_data); end
      end
    end
    wr_valid = 1'b0; clear_start = 1'b0; rd_en = 1'b0;
    checks++; if (busy_cnt != 19200) begin errors++; $display("FAIL clr_busy_len got %0d exp 19200", busy_cnt); end
    checks++; if (rdy_bad != 0) begin errors++; $display("FAIL clr_wr_ready got %0d high cycles exp 0", rdy_bad); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL clr_done_early got %0d exp 0", done_cnt); end
    checks++; if (clear_done !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL clr_done_pulse got done=%b rdy=%b exp 1/0", clear_done, wr_ready); end
    step();
    checks++; if (clear_done !== 1'b0 || wr_ready !== 1'b1 || clear_busy !== 1'b0) begin errors++; $display("FAIL clr_back_idle got done=%b rdy=%b busy=%b exp 0/1/0", clear_done, wr_ready, clear_busy); end
    fill_model('h3);
    do_read(0, 0);
    checks++; if (rd_data !== 4'h3) begin errors++; $display("FAIL clr_rd_0_0 got %h exp 3", rd_data); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL clr_done_once got %b exp 0", clear_done); end
    do_read(80, 60);
    checks++; if (rd_data !== 4'h3) begin errors++; $display("FAIL clr_rd_80_60 got %h exp 3", rd_data); end
    do_read(159, 119);
    checks++; if (rd_data !== 4'h3) begin errors++; $display("FAIL clr_rd_159_119 got %h exp 3", rd_data); end
  endtask

  task automatic test_back_to_back();
    int n;
    wr_valid = 1'b1; wr_x = 159; wr_y = 119; wr_data = 'h6;
    clear_start = 1'b1; clear_colour = 'h1;
    step();
    wr_valid = 1'b0; clear_start = 1'b0;
    do_read(159, 119);
    checks++; if (rd_data !== 4'h6) begin errors++; $display("FAIL b2b_write_landed got %h exp 6", rd_data); end
    n = 0;
    while (clear_busy === 1'b1 && n < 20000) begin n++; step(); end
    checks++; if (n >= 20000) begin errors++; $display("FAIL b2b_timeout got %0d cycles", n); end
    step();
    fill_model('h1);
    do_read(159, 119);
    checks++; if (rd_data !== 4'h1) begin errors++; $display("FAIL b2b_overwritten got %h exp 1", rd_data); end
  endtask

  task automatic test_reset_mid_clear();
    int done_seen;
    int addrs [8];
    int exps [8];
    addrs = '{0, 50, 99, 100, 101, 500, 12345, 19199};
    exps  = '{9, 9, 9, 1, 1, 1, 1, 1};
    done_seen = 0;
    clear_colour = 'h9; clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (100) begin step(); if (clear_done === 1'b1) done_seen++; end
    reset = 1'b1;
    #1;
    checks++; if (clear_busy !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL rmc_async got busy=%b rdy=%b exp 0/0", clear_busy, wr_ready); end
    repeat (2) begin step(); if (clear_done === 1'b1) done_seen++; end
    reset = 1'b0;
    step();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmc_ready got %b exp 1", wr_ready); end
    repeat (5) begin step(); if (clear_done === 1'b1) done_seen++; end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL rmc_no_done got %0d exp 0", done_seen); end
    for (int i = 0; i < 8; i++) begin
      do_read(addrs[i] % HR, addrs[i] / HR);
      checks++; if (rd_data !== DW'(exps[i])) begin errors++; $display("FAIL rmc_addr_%0d got %h exp %h", addrs[i], rd_data, exps[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin model[i] = 0; known[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_oob();
    test_forward();
    test_random();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
